mem_arbiter: RTL and testbench

Byte-serial memory arbiter between the load/store buffer (LSB), the instruction cache and the single-port byte-wide RAM/IO bus. Successor of the current memory controller, with four additions:
- parametrised cache-line burst fills;
- a stall on `io_buffer_full` for IO writes;
- `clr` abort of speculative reads;
- a registered valid/done handshake per channel.

Sits between `lsb`/`icache` and the top-level RAM port.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and the IO-region predicate for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LSB_RD = 3'd1,
    LSB_WR = 3'd2,
    IC_RD  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  localparam logic [7:0] NULL8 = 8'h00;

  // IO accesses hit a fixed device register, so every beat reuses the base address.
  function automatic logic io_region(input logic [1:0] addr_17_16);
    return addr_17_16 == 2'b11;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter of LSB and icache onto one byte-wide RAM/IO port; LSB wins ties.
// Latency: read N bytes -> done N+2 cycles after accept, write -> N+1 plus IO stalls; io_buffer_full holds IO write beats, rdy=0 freezes everything.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int LINE_BYTES    = 16,
  parameter int MAX_LSB_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       clr,
  input  logic                       lsb_valid,
  input  logic                       lsb_write,
  input  logic [ADDR_W-1:0]          lsb_addr,
  input  logic [2:0]                 lsb_len,
  input  logic [8*MAX_LSB_BYTES-1:0] lsb_wdata,
  output logic                       lsb_done,
  output logic [8*MAX_LSB_BYTES-1:0] lsb_rdata,
  input  logic                       ic_valid,
  input  logic [ADDR_W-1:0]          ic_addr,
  output logic                       ic_done,
  output logic [8*LINE_BYTES-1:0]    ic_rdata,
  input  logic                       io_buffer_full,
  output logic [ADDR_W-1:0]          mem_a,
  output logic [7:0]                 mem_dout,
  input  logic [7:0]                 mem_din,
  output logic                       mem_wr
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, len_q, len_d;
  logic [CNT_W-1:0]           lsb_n, nxt;
  logic [ADDR_W-1:0]          base_q, base_d, addr_q, addr_d, nxt_addr;
  logic [8*MAX_LSB_BYTES-1:0] wdata_q, wdata_d;
  logic [7:0]                 dout_q, dout_d;
  logic [8*LINE_BYTES-1:0]    line_q, line_d;
  logic                       lsb_own_q, lsb_own_d, dir_q, dir_d;
  logic                       io_base, stall, accept_lsb, accept_ic, last_beat;
  logic [OFF_W-1:0]           cap_idx;

  assign io_base    = io_region(base_q[17:16]);
  assign stall      = (state_q == LSB_WR) && io_base && io_buffer_full;
  assign nxt        = cnt_q + CNT_W'(1);
  assign nxt_addr   = io_base ? base_q : base_q + ADDR_W'(nxt);
  assign last_beat  = (nxt == len_q);
  assign cap_idx    = OFF_W'(cnt_q - CNT_W'(1));
  assign accept_lsb = !clr && lsb_valid;
  assign accept_ic  = !clr && !lsb_valid && ic_valid;

  always_comb begin
    if (lsb_len == 3'd0) begin
      lsb_n = CNT_W'(LEN_BYTE);
    end else if (32'(lsb_len) > MAX_LSB_BYTES) begin
      lsb_n = CNT_W'(MAX_LSB_BYTES);
    end else begin
      lsb_n = CNT_W'(lsb_len);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_q    <= NULL8;
      line_q    <= '0;
      lsb_own_q <= 1'b0;
      dir_q     <= READ;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
      line_q    <= line_d;
      lsb_own_q <= lsb_own_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (accept_lsb)     state_d = lsb_write ? LSB_WR : LSB_RD;
          else if (accept_ic) state_d = IC_RD;
        end
        LSB_RD, IC_RD: begin
          if (clr)                 state_d = IDLE;
          else if (cnt_q == len_q) state_d = DONE;
        end
        LSB_WR: begin
          if (!stall && last_beat) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    base_d    = base_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    line_d    = line_q;
    lsb_own_d = lsb_own_q;
    dir_d     = dir_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (accept_lsb || accept_ic) begin
            // Clearing the line buffer is what zero-extends short LSB loads.
            cnt_d     = '0;
            line_d    = '0;
            lsb_own_d = accept_lsb;
            dir_d     = accept_lsb ? lsb_write : READ;
            wdata_d   = lsb_wdata;
            len_d     = accept_lsb ? lsb_n : CNT_W'(LINE_BYTES);
            base_d    = accept_lsb ? lsb_addr : (ic_addr & LINE_MASK);
            addr_d    = base_d;
            dout_d    = (accept_lsb && lsb_write) ? lsb_wdata[7:0] : NULL8;
          end
        end
        LSB_RD, IC_RD: begin
          if (clr) begin
            addr_d = '0;
          end else begin
            // mem_din carries the byte of the previous beat.
            if (cnt_q != '0) line_d[{cap_idx, 3'b000} +: 8] = mem_din;
            cnt_d  = nxt;
            addr_d = (nxt < len_q) ? nxt_addr : '0;
          end
        end
        LSB_WR: begin
          if (!stall) begin
            if (last_beat) begin
              addr_d = '0;
              dout_d = NULL8;
            end else begin
              cnt_d  = nxt;
              addr_d = nxt_addr;
              dout_d = 8'(wdata_q >> {nxt, 3'b000});
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_a     = addr_q;
    mem_dout  = dout_q;
    mem_wr    = rdy && (state_q == LSB_WR) && !stall;
    lsb_done  = rdy && (state_q == DONE) && lsb_own_q && !(clr && dir_q == READ);
    ic_done   = rdy && (state_q == DONE) && !lsb_own_q && !clr;
    lsb_rdata = line_q[8*MAX_LSB_BYTES-1:0];
    ic_rdata  = line_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected writes and done pulses are queued at drive time.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LB = 16;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rdy = 1'b1;
  logic            clr = 1'b0;
  logic            lsb_valid = 1'b0;
  logic            lsb_write = 1'b0;
  logic [AW-1:0]   lsb_addr = '0;
  logic [2:0]      lsb_len = '0;
  logic [8*MB-1:0] lsb_wdata = '0;
  logic            lsb_done;
  logic [8*MB-1:0] lsb_rdata;
  logic            ic_valid = 1'b0;
  logic [AW-1:0]   ic_addr = '0;
  logic            ic_done;
  logic [8*LB-1:0] ic_rdata;
  logic            io_buffer_full = 1'b0;
  logic [AW-1:0]   mem_a;
  logic [7:0]      mem_dout;
  logic [7:0]      mem_din;
  logic            mem_wr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_BYTES(LB), .MAX_LSB_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .lsb_valid(lsb_valid), .lsb_write(lsb_write), .lsb_addr(lsb_addr),
    .lsb_len(lsb_len), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .io_buffer_full(io_buffer_full), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_wr(mem_wr)
  );

  logic [7:0] ram [0:65535];
  always @(posedge clk) mem_din <= ram[mem_a[15:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [127:0] data; bit chk; int cyc; } done_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
  done_t lsb_q[$];
  done_t ic_q[$];
  wr_t   wq[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_wr = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int norm_len(input logic [2:0] len);
    if (len == 3'd0) return 1;
    if (len > 3'd4) return 4;
    return int'(len);
  endfunction

  function automatic logic [31:0] beat_a(input logic [31:0] base, input int k);
    return (base[17:16] == 2'b11) ? base : base + 32'(k);
  endfunction

  function automatic logic [127:0] read_bytes(input logic [31:0] base, input int n);
    logic [127:0] d;
    logic [31:0]  a;
    d = '0;
    for (int k = 0; k < n; k++) begin
      a = beat_a(base, k);
      d[8*k +: 8] = ram[a[15:0]];
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] a, input logic [2:0] len);
    done_t e;
    int n;
    n = norm_len(len);
    e.data = read_bytes(a, n);
    e.chk = 1'b1;
    e.cyc = cyc + n + 2;
    lsb_q.push_back(e);
    lsb_valid = 1'b1; lsb_write = 1'b0; lsb_addr = a; lsb_len = len; lsb_wdata = '0;
  endtask

  task automatic start_store(input logic [31:0] a, input logic [2:0] len,
                             input logic [31:0] wd, input int extra);
    done_t e;
    wr_t   w;
    int    n;
    n = norm_len(len);
    for (int k = 0; k < n; k++) begin
      w.addr = beat_a(a, k);
      w.data = wd[8*k +: 8];
      wq.push_back(w);
    end
    e.data = '0;
    e.chk = 1'b0;
    e.cyc = cyc + 1 + n + extra;
    lsb_q.push_back(e);
    lsb_valid = 1'b1; lsb_write = 1'b1; lsb_addr = a; lsb_len = len; lsb_wdata = wd;
  endtask

  task automatic wait_done(input bit ic);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ic ? ic_done : lsb_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(ic ? "ic_done_timeout" : "lsb_done_timeout", 128'(0), 128'(1));
    step();
    if (ic) ic_valid = 1'b0;
    else    lsb_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_a"},     128'(mem_a),     128'(0));
    check({tag, "_mem_wr"},    128'(mem_wr),    128'(0));
    check({tag, "_mem_dout"},  128'(mem_dout),  128'(0));
    check({tag, "_lsb_done"},  128'(lsb_done),  128'(0));
    check({tag, "_ic_done"},   128'(ic_done),   128'(0));
    check({tag, "_lsb_rdata"}, 128'(lsb_rdata), 128'(0));
    check({tag, "_ic_rdata"},  128'(ic_rdata),  128'(0));
  endtask

  // Scoreboard side: every write beat and done pulse must match the head of its queue.
  always @(negedge clk) begin
    done_t e;
    wr_t   w;
    if (rst) begin
      if (mem_wr) begin
        n_wr++;
        if (wq.size() == 0) begin
          check("wr_unexpected", 128'(1), 128'(0));
        end else begin
          w = wq.pop_front();
          check("wr_addr", 128'(mem_a), 128'(w.addr));
          check("wr_data", 128'(mem_dout), 128'(w.data));
        end
      end
      if (lsb_done || ic_done) check("done_overlap", 128'(lsb_done && ic_done), 128'(0));
      if (lsb_done) begin
        if (lsb_q.size() == 0) begin
          check("lsb_done_unexpected", 128'(1), 128'(0));
        end else begin
          e = lsb_q.pop_front();
          check("lsb_done_cycle", 128'(cyc), 128'(e.cyc));
          if (e.chk) check("lsb_rdata", 128'(lsb_rdata), e.data);
        end
      end
      if (ic_done) begin
        if (ic_q.size() == 0) begin
          check("ic_done_unexpected", 128'(1), 128'(0));
        end else begin
          e = ic_q.pop_front();
          check("ic_done_cycle", 128'(cyc), 128'(e.cyc));
          check("ic_rdata", ic_rdata, e.data);
        end
      end
    end
  end

  logic [31:0] ta [5] = '{32'h0000_0105, 32'h0000_0108, 32'hFFFF_FFFE, 32'h0003_0010, 32'h0000_0050};
  logic [2:0]  tl [5] = '{3'd0, 3'd7, 3'd4, 3'd4, 3'd2};

  initial begin
    done_t e;
    int    wr0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 7 + 3);
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22;
    ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    // Word load: beats on 0x100..0x103, data 0x44332211.
    step();
    start_load(32'h0000_0100, 3'd4);
    check("ld_word_model", lsb_q[0].data, 128'(32'h4433_2211));
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ld_beat_addr", 128'(mem_a), 128'(32'h100 + k));
    end
    wait_done(1'b0);

    // Length 0 and 7, address wrap, IO-region read, halfword.
    for (int i = 0; i < 5; i++) begin
      step();
      start_load(ta[i], tl[i]);
      wait_done(1'b0);
    end

    // LSB and icache together: LSB first, line fill of 0x1000 after it.
    step();
    start_load(32'h0000_2003, 3'd2);
    ic_valid = 1'b1;
    ic_addr = 32'h0000_1005;
    e.data = read_bytes(32'h0000_1000, 16);
    e.chk = 1'b1;
    e.cyc = cyc + 23;
    ic_q.push_back(e);
    wait_done(1'b0);
    wait_done(1'b1);

    // IO byte store held for 3 cycles by io_buffer_full.
    step();
    wr0 = n_wr;
    start_store(32'h0003_0000, 3'd1, 32'h41, 3);
    io_buffer_full = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("io_stall_no_wr", 128'(mem_wr), 128'(0));
    end
    step();
    io_buffer_full = 1'b0;
    wait_done(1'b0);
    check("io_store_wr_count", 128'(n_wr - wr0), 128'(1));

    // clr during a word store is ignored.
    step();
    wr0 = n_wr;
    start_store(32'h0000_0200, 3'd4, 32'hDDCC_BBAA, 0);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    wait_done(1'b0);
    check("sw_clr_wr_count", 128'(n_wr - wr0), 128'(4));

    // clr in the DONE cycle of a byte load suppresses the pulse.
    step();
    lsb_valid = 1'b1; lsb_write = 1'b0; lsb_addr = 32'h0000_0140; lsb_len = 3'd1;
    repeat (3) step();
    clr = 1'b1;
    @(negedge clk);
    check("ld_clr_done_suppressed", 128'(lsb_done), 128'(0));
    step();
    clr = 1'b0;
    lsb_valid = 1'b0;
    repeat (4) step();

    // clr during beat 2 of a line fill aborts it.
    step();
    ic_valid = 1'b1;
    ic_addr = 32'h0000_1000;
    repeat (3) step();
    clr = 1'b1;
    ic_valid = 1'b0;
    @(negedge clk);
    check("ic_clr_beat2_addr", 128'(mem_a), 128'(32'h1002));
    step();
    clr = 1'b0;
    @(negedge clk);
    check("ic_clr_mem_a", 128'(mem_a), 128'(0));
    repeat (25) step();

    // rdy low for 5 cycles in beat 1 of a halfword store.
    step();
    wr0 = n_wr;
    start_store(32'h0000_0300, 3'd2, 32'h0000_BEEF, 5);
    step();
    step();
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rdy_low_no_wr", 128'(mem_wr), 128'(0));
    end
    step();
    rdy = 1'b1;
    wait_done(1'b0);
    check("sh_rdy_wr_count", 128'(n_wr - wr0), 128'(2));

    // Asynchronous reset in the middle of a fill, then a normal load.
    step();
    ic_valid = 1'b1;
    ic_addr = 32'h0000_2000;
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("arst");
    ic_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    start_load(32'h0000_0100, 3'd4);
    wait_done(1'b0);

    repeat (5) step();
    check("lsb_q_drained", 128'(lsb_q.size()), 128'(0));
    check("ic_q_drained", 128'(ic_q.size()), 128'(0));
    check("wr_q_drained", 128'(wq.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
